// File: rtl/alu8_seq.sv
// Two-pass sequencer: runs 8-bit ALU commands as low-nibble then high-nibble passes on a 4-bit ALU.
// Optional macro ALU8_ACC_EN: use_acc=1 at accept takes operand A from the result register.
module alu8_seq (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [2:0] op,
  input  logic       c_in,
  input  logic       use_acc,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic       alu_cin,
  output logic [2:0] alu_op,
  input  logic [3:0] alu_r,
  input  logic       alu_carry,
  input  logic       alu_zero,
  input  logic       alu_sign,
  output logic [7:0] result,
  output logic       carry,
  output logic       zero,
  output logic       sign,
  output logic       busy,
  output logic       done
);

  localparam int unsigned DW = 8;
  localparam int unsigned NW = 4;
  localparam int unsigned OW = 3;

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t        state;
  logic [DW-1:0] a_q;
  logic [DW-1:0] b_q;
  logic [OW-1:0] op_q;
  logic          c_in_q;
  logic          carry_lo;
  logic          zero_lo;
  logic [DW-1:0] a_sel;

`ifdef ALU8_ACC_EN
  assign a_sel = use_acc ? result : a;
`else
  logic unused_use_acc;
  assign unused_use_acc = use_acc;
  assign a_sel = a;
`endif

  // Sequencer state, command latch and result/flag capture
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      c_in_q   <= 1'b0;
      carry_lo <= 1'b0;
      zero_lo  <= 1'b0;
      result   <= '0;
      carry    <= 1'b0;
      zero     <= 1'b0;
      sign     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_q    <= a_sel;
            b_q    <= b;
            op_q   <= op;
            c_in_q <= c_in;
            busy   <= 1'b1;
            state  <= LO;
          end else begin
            state  <= IDLE;
          end
        end
        LO: begin
          result[NW-1:0] <= alu_r;
          carry_lo       <= alu_carry;
          zero_lo        <= alu_zero;
          state          <= HI;
        end
        HI: begin
          result[DW-1:NW] <= alu_r;
          // Logic ops never produce a carry, whatever the ALU reports.
          carry <= op_q[2] ? 1'b0 : alu_carry;
          zero  <= zero_lo & alu_zero;
          sign  <= alu_sign;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ALU drive is purely a function of state and the latched command
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_cin = 1'b0;
    alu_op  = '0;
    case (state)
      LO: begin
        alu_a   = a_q[NW-1:0];
        alu_b   = b_q[NW-1:0];
        alu_op  = op_q;
        alu_cin = op_q[2] ? 1'b0 : c_in_q;
      end
      HI: begin
        alu_a   = a_q[DW-1:NW];
        alu_b   = b_q[DW-1:NW];
        alu_op  = op_q;
        alu_cin = op_q[2] ? 1'b0 : carry_lo;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu8_seq.sv
// Directed bench for alu8_seq with a behavioural 4-bit ALU model attached to its ALU port.
module tb_alu8_seq;

  logic       clk = 1'b0;
  logic       reset, start, c_in, use_acc;
  logic [7:0] a, b;
  logic [2:0] op;
  logic [3:0] alu_a, alu_b, alu_r;
  logic       alu_cin, alu_carry, alu_zero, alu_sign;
  logic [2:0] alu_op;
  logic [7:0] result;
  logic       carry, zero, sign, busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  alu8_seq dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .op(op),
    .c_in(c_in), .use_acc(use_acc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_op(alu_op),
    .alu_r(alu_r), .alu_carry(alu_carry), .alu_zero(alu_zero), .alu_sign(alu_sign),
    .result(result), .carry(carry), .zero(zero), .sign(sign),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // 4-bit ALU: 0x0 add, 0x1 sub (a + ~b + cin); 1x0 and, 1x1 or, 1x2 xor, 1x3 not a
  logic [4:0] sum5;
  always_comb begin
    sum5      = 5'({1'b0, alu_a} + {1'b0, (alu_op[0] ? ~alu_b : alu_b)} + 5'(alu_cin));
    alu_carry = 1'b0;
    if (!alu_op[2]) begin
      alu_r     = sum5[3:0];
      alu_carry = sum5[4];
    end else begin
      case (alu_op[1:0])
        2'd0:    alu_r = alu_a & alu_b;
        2'd1:    alu_r = alu_a | alu_b;
        2'd2:    alu_r = alu_a ^ alu_b;
        default: alu_r = ~alu_a;
      endcase
    end
    alu_zero = (alu_r == 4'd0);
    alu_sign = alu_r[3];
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
    end
  endtask

  // Present a command for one edge; returns at the negedge inside LO
  task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic [2:0] iop,
                       input logic icin, input logic iacc);
    @(negedge clk);
    a = ia; b = ib; op = iop; c_in = icin; use_acc = iacc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic       cin;
    logic [7:0] r;
    logic       c;
    logic       z;
    logic       s;
    logic       hcin;
  } vec_t;

  vec_t vec [10];
  logic [9:0] done_seen;
  logic [7:0] first_r;

  initial begin
    vec[0] = '{8'h3F, 8'h01, 3'b000, 1'b0, 8'h40, 1'b0, 1'b0, 1'b0, 1'b1};
    vec[1] = '{8'hFF, 8'h01, 3'b000, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1};
    vec[2] = '{8'hF0, 8'h3C, 3'b100, 1'b1, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0};
    vec[3] = '{8'hF0, 8'h3C, 3'b110, 1'b0, 8'hCC, 1'b0, 1'b0, 1'b1, 1'b0};
    vec[4] = '{8'h12, 8'h34, 3'b000, 1'b1, 8'h47, 1'b0, 1'b0, 1'b0, 1'b0};
    vec[5] = '{8'h50, 8'h20, 3'b001, 1'b1, 8'h30, 1'b1, 1'b0, 1'b0, 1'b1};
    vec[6] = '{8'hF0, 8'h0F, 3'b101, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0};
    vec[7] = '{8'h55, 8'hAA, 3'b100, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    vec[8] = '{8'h80, 8'h80, 3'b000, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    vec[9] = '{8'h0F, 8'h00, 3'b111, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b1, 1'b0};

    reset = 1'b1; start = 1'b0; a = '0; b = '0; op = '0; c_in = 1'b0; use_acc = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset_result", result, 8'h00);
    check("reset_flags", {5'd0, carry, zero, sign}, 8'h00);
    check("reset_busy_done", {6'd0, busy, done}, 8'h00);
    check("reset_alu_a", {4'd0, alu_a}, 8'h00);

    // Table-driven single commands
    for (int i = 0; i < 10; i++) begin
      issue(vec[i].a, vec[i].b, vec[i].op, vec[i].cin, 1'b0);
      check($sformatf("v%0d_lo_busy", i), {7'd0, busy}, 8'h01);
      check($sformatf("v%0d_lo_cin", i), {7'd0, alu_cin}, {7'd0, vec[i].op[2] ? 1'b0 : vec[i].cin});
      check($sformatf("v%0d_lo_alu_a", i), {4'd0, alu_a}, {4'd0, vec[i].a[3:0]});
      @(negedge clk);
      check($sformatf("v%0d_hi_cin", i), {7'd0, alu_cin}, {7'd0, vec[i].hcin});
      check($sformatf("v%0d_hi_alu_b", i), {4'd0, alu_b}, {4'd0, vec[i].b[7:4]});
      check($sformatf("v%0d_hi_done", i), {7'd0, done}, 8'h00);
      @(negedge clk);
      check($sformatf("v%0d_done", i), {6'd0, busy, done}, 8'h01);
      check($sformatf("v%0d_result", i), result, vec[i].r);
      check($sformatf("v%0d_flags", i), {5'd0, carry, zero, sign},
            {5'd0, vec[i].c, vec[i].z, vec[i].s});
      check($sformatf("v%0d_alu_idle", i), {alu_a, alu_b}, 8'h00);
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", i), {7'd0, done}, 8'h00);
    end

    // start held for 6 edges: exactly two done pulses at t+3 and t+6
    @(negedge clk);
    a = 8'h21; b = 8'h13; op = 3'b000; c_in = 1'b0; start = 1'b1;
    done_seen = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 5) start = 1'b0;
      done_seen[k] = done;
    end
    check("b2b_done_pattern", done_seen[7:0], 8'b0010_0100);
    check("b2b_done_tail", {6'd0, done_seen[9:8]}, 8'h00);
    check("b2b_result", result, 8'h34);

    // start pulses in LO and HI must not disturb the running command
    issue(8'h0A, 8'h05, 3'b000, 1'b0, 1'b0);
    a = 8'hEE; b = 8'hEE; op = 3'b110; start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    check("ign_done", {7'd0, done}, 8'h01);
    check("ign_result", result, 8'h0F);
    @(negedge clk);
    check("ign_no_requeue", {6'd0, busy, done}, 8'h00);

    // Reset held two cycles starting mid-HI
    issue(8'h77, 8'h11, 3'b000, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_result", result, 8'h00);
    check("rst_mid_busy_done", {6'd0, busy, done}, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_flags", {5'd0, carry, zero, sign}, 8'h00);
    done_seen = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      done_seen[k] = done | busy;
    end
    check("rst_no_done", {4'd0, done_seen[3:0]}, 8'h00);
    check("rst_result_held", result, 8'h00);

    // Accumulation: second command may take A from the result register
    issue(8'h10, 8'h05, 3'b000, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    first_r = result;
    check("acc_first", first_r, 8'h15);
    issue(8'h77, 8'h05, 3'b000, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    check("acc_done", {7'd0, done}, 8'h01);
`ifdef ALU8_ACC_EN
    check("acc_second", result, 8'h1A);
`else
    check("acc_second", result, 8'h7C);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
